// File: rtl/div_iter_pkg.sv
// Shared types for the iterative divider: FSM states and the ALU op encoding
// that execute uses to pick quotient or remainder.
package div_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic div;
        logic divu;
        logic rem;
        logic remu;
    } aluop_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left by one bit and
// conditionally subtract the divisor magnitude.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic           ge;

    // The compare runs at WIDTH+1 bits; once it passes, the true difference
    // is below the divisor and fits in WIDTH bits.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        ge      = shifted >= {1'b0, dvs_i};
        rem_o   = ge ? (shifted[WIDTH-1:0] - dvs_i) : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_iter.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), STEP quotient bits per cycle,
// answering execute's go/done handshake with quotient and remainder together.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk_core,
    input  logic             reset_n,
    input  logic             go,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy
);

    localparam int NITER = WIDTH / STEP;
    localparam int CNT_W = $clog2(NITER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NITER - 1);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_out_q, rem_out_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             neg_q_q, neg_r_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] rem_c [STEP+1];
    logic [WIDTH-1:0] quo_c [STEP+1];

    always_comb begin
        dvd_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_mag = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;

    for (genvar s = 0; s < STEP; s++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_i (rem_c[s]),
            .quo_i (quo_c[s]),
            .dvs_i (dvs_q),
            .rem_o (rem_c[s+1]),
            .quo_o (quo_c[s+1])
        );
    end

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go) begin
                        if (divisor == '0) begin
                            quo_out_q <= '1;
                            rem_out_q <= dividend;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else if (sign && dividend == SMIN && divisor == '1) begin
                            quo_out_q <= dividend;
                            rem_out_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            quo_q   <= dvd_mag;
                            dvs_q   <= dvs_mag;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            neg_q_q <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_r_q <= sign & dividend[WIDTH-1];
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    // Dropping go mid-iteration is how execute flushes/kills an op.
                    if (!go) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_c[STEP];
                        quo_q <= quo_c[STEP];
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            quo_out_q <= neg_q_q ? -quo_c[STEP] : quo_c[STEP];
                            rem_out_q <= neg_r_q ? -rem_c[STEP] : rem_c[STEP];
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done      = done_q;
    assign quotient  = quo_out_q;
    assign remainder = rem_out_q;
    assign busy      = (state_q != IDLE);

endmodule
